// File: rtl/switch_debounce_led_ctrl.sv
// Purpose: synchronise and debounce NUM_CH switches, emit press pulses, drive LEDs in one of four display modes.
// Latency: a new switch level reaches o_LED/o_Press_Pulse DEBOUNCE_CYCLES+2 edges after it is first sampled; mode changes take 2 edges.
// Backpressure: none; outputs are free-running registered levels and pulses.
module switch_debounce_led_ctrl #(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_CH-1:0] i_Switch,
  input  logic [1:0]        i_Mode,
  output logic [NUM_CH-1:0] o_LED,
  output logic [NUM_CH-1:0] o_Press_Pulse
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_INVERT = 2'b01;
  localparam logic [1:0] MODE_TOGGLE = 2'b10;
  localparam logic [1:0] MODE_COUNT  = 2'b11;

  logic [NUM_CH-1:0] sync_meta;
  logic [NUM_CH-1:0] sync_out;
  logic [NUM_CH-1:0] stable;
  logic [NUM_CH-1:0] stable_d;
  logic [CNT_W-1:0]  db_cnt [NUM_CH];
  logic [NUM_CH-1:0] tog;
  logic [NUM_CH-1:0] press_cnt;
  logic [1:0]        mode_q;

  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] tog_next;
  logic [NUM_CH-1:0] cnt_next;
  logic [NUM_CH-1:0] led_next;

  // Two-flop synchroniser for the asynchronous switch pins; mode is registered once.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_meta <= '0;
      sync_out  <= '0;
      mode_q    <= '0;
    end else begin
      sync_meta <= i_Switch;
      sync_out  <= sync_meta;
      mode_q    <= i_Mode;
    end
  end

  // Per-channel debounce: a differing level must persist DEBOUNCE_CYCLES consecutive clocks.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      stable <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sync_out[i] != stable[i]) begin
          if (db_cnt[i] == CNT_LAST) begin
            stable[i] <= sync_out[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Toggle and counter next-state feed the LED mux directly, so every mode
  // updates on the same edge as the press pulse.
  always_comb begin
    rise     = stable & ~stable_d;
    tog_next = tog ^ rise;
    cnt_next = press_cnt + NUM_CH'(rise != '0);
    case (mode_q)
      MODE_DIRECT: led_next = stable;
      MODE_INVERT: led_next = ~stable;
      MODE_TOGGLE: led_next = tog_next;
      MODE_COUNT:  led_next = cnt_next;
      default:     led_next = stable;
    endcase
  end

  // Edge-detect history, toggle/counter state and registered outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      stable_d      <= '0;
      tog           <= '0;
      press_cnt     <= '0;
      o_LED         <= '0;
      o_Press_Pulse <= '0;
    end else begin
      stable_d      <= stable;
      tog           <= tog_next;
      press_cnt     <= cnt_next;
      o_LED         <= led_next;
      o_Press_Pulse <= rise;
    end
  end

endmodule

// File: tb/tb_switch_debounce_led_ctrl.sv
// Purpose: scoreboard bench for switch_debounce_led_ctrl with directed scenarios and random switch/mode/reset traffic.
// Latency: a windowed reference model predicts each post-reset cycle's outputs; a negedge monitor compares them.
// Backpressure: none; every clock after reset release yields one expected output entry.
module tb_switch_debounce_led_ctrl;

  localparam int N = 4;
  localparam int D = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] sw;
  logic [1:0]   mode;
  logic [N-1:0] led;
  logic [N-1:0] pulse;

  int checks = 0;
  int errors = 0;

  switch_debounce_led_ctrl #(.NUM_CH(N), .DEBOUNCE_CYCLES(D)) dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_Switch      (sw),
    .i_Mode        (mode),
    .o_LED         (led),
    .o_Press_Pulse (pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {led, pulse} per clock edge since reset release.
  logic [2*N-1:0] exp_q[$];

  // Reference model state.
  int           n_edge;
  logic [N-1:0] raw_hist[$];
  logic [N-1:0] syn_hist[$];
  logic [N-1:0] m_st1, m_st2, m_tog, m_cnt, m_new, m_rise, m_led, m_syn;
  logic [1:0]   m_mode;
  bit           m_all;

  // Model: the debounce sees each raw sample two edges late; a channel's accepted
  // level flips once its last D synced samples all differ from it. Outputs after an
  // edge reflect the accepted level from the previous edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      n_edge = 0;
      raw_hist.delete();
      syn_hist.delete();
      m_st1 = '0; m_st2 = '0; m_tog = '0; m_cnt = '0; m_mode = '0;
    end else begin
      n_edge++;
      raw_hist.push_back(sw);
      m_syn = (n_edge >= 3) ? raw_hist[n_edge-3] : '0;
      syn_hist.push_back(m_syn);
      m_new = m_st1;
      if (n_edge >= D) begin
        for (int ch = 0; ch < N; ch++) begin
          m_all = 1'b1;
          for (int k = 0; k < D; k++)
            if (syn_hist[n_edge-1-k][ch] == m_st1[ch]) m_all = 1'b0;
          if (m_all) m_new[ch] = ~m_st1[ch];
        end
      end
      m_rise = m_st1 & ~m_st2;
      m_tog  = m_tog ^ m_rise;
      if (m_rise != '0) m_cnt = m_cnt + 1'b1;
      case (m_mode)
        2'd0: m_led = m_st1;
        2'd1: m_led = ~m_st1;
        2'd2: m_led = m_tog;
        default: m_led = m_cnt;
      endcase
      exp_q.push_back({m_led, m_rise});
      m_mode = mode;
      m_st2  = m_st1;
      m_st1  = m_new;
    end
  end

  // Monitor: outputs are held at zero in reset, otherwise each cycle pops one expectation.
  logic [2*N-1:0] exp_v;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      checks++;
      if (led != '0 || pulse != '0) begin
        errors++;
        $display("FAIL reset_outputs t=%0t led=%b pulse=%b required led=0000 pulse=0000", $time, led, pulse);
      end
    end else if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if ({led, pulse} != exp_v) begin
        errors++;
        $display("FAIL outputs t=%0t led=%b pulse=%b required led=%b pulse=%b",
                 $time, led, pulse, exp_v[2*N-1:N], exp_v[N-1:0]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input logic [N-1:0] m, input int hold, input int gap);
    sw = m;
    cyc(hold);
    sw = '0;
    cyc(gap);
  endtask

  initial begin
    rst_n = 1'b0;
    sw    = '0;
    mode  = 2'd0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // Direct mode: clean press and release of channel 0.
    press(4'b0001, 12, 12);

    // Short glitch then bounce on channel 2: must never be accepted.
    sw = 4'b0100; cyc(3);
    sw = 4'b0000; cyc(1);
    sw = 4'b0100; cyc(1);
    sw = 4'b0000; cyc(1);
    sw = 4'b0100; cyc(1);
    sw = 4'b0000; cyc(10);

    // Toggle mode: three presses on channel 1, then mode hops.
    mode = 2'd2;
    repeat (3) press(4'b0010, 8, 8);
    mode = 2'd0; cyc(4);
    mode = 2'd2; cyc(4);

    // Counter mode: 17 presses wrap the counter, then a simultaneous two-channel press.
    mode = 2'd3;
    repeat (17) press(4'b1000, 8, 8);
    press(4'b1001, 8, 8);

    // Inverted mode straight out of reset, then a press on channel 0.
    mode  = 2'd1;
    rst_n = 1'b0; cyc(2);
    rst_n = 1'b1; cyc(4);
    press(4'b0001, 10, 10);

    // Reset part-way through a debounce with the switch held across it.
    mode = 2'd0;
    sw   = 4'b0001; cyc(4);
    rst_n = 1'b0; cyc(2);
    rst_n = 1'b1; cyc(12);
    sw = '0; cyc(10);

    // Random switch traffic with occasional mode changes and resets.
    for (int t = 0; t < 3000; t++) begin
      for (int ch = 0; ch < N; ch++)
        if ($urandom_range(0, 5) == 0) sw[ch] = ~sw[ch];
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        cyc($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      cyc(1);
    end

    sw = '0;
    cyc(20);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain leftover=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
